// File: rtl/array_11_queue.sv
// 18-entry FIFO over a 16x28 single-port SRAM plus a 2-entry output buffer. Bypass: deq valid 1 cycle after enq, RAM path 3 cycles.
// Backpressure: reads own the port, so enqueue stalls while the RAM drains. io_deq_ready reaches io_enq_ready combinationally.
module array_11_queue #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 28,
  parameter int OB_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [4:0]       io_count,
  output logic [3:0]       mem_addr,
  output logic             mem_en,
  output logic             mem_wmode,
  output logic [1:0]       mem_wmask,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  logic [3:0]       wr_ptr;
  logic [3:0]       rd_ptr;
  logic [4:0]       r_cnt;
  logic             inflight;
  logic [1:0]       ob_cnt;
  logic             ob_head;
  logic [WIDTH-1:0] ob_dat [OB_DEPTH];
  logic [3:0]       addr_q;
  logic [WIDTH-1:0] wdata_q;

  logic             deq_fire;
  logic [2:0]       ob_sum;
  logic             ob_credit;
  logic             rd_issue;
  logic             bypass_ok;
  logic             wr_ok;
  logic             enq_fire;
  logic             wr_fire;
  logic             ob_push;
  logic             ob_tail;
  logic [WIDTH-1:0] ob_push_dat;

  assign io_deq_valid = (ob_cnt != 2'd0);
  assign io_deq_bits  = ob_dat[ob_head];
  assign deq_fire     = io_deq_valid & io_deq_ready;

  // Buffer slots that would be committed after this cycle, counting a read already in flight.
  assign ob_sum    = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, deq_fire};
  assign ob_credit = (ob_sum < 3'd2);

  assign rd_issue  = !reset & (r_cnt != 5'd0) & ob_credit;
  assign bypass_ok = !reset & (r_cnt == 5'd0) & !inflight & ob_credit;
  assign wr_ok     = !reset & !rd_issue & !bypass_ok & (r_cnt < 5'(DEPTH));

  assign io_enq_ready = bypass_ok | wr_ok;
  assign enq_fire     = io_enq_valid & io_enq_ready;
  assign wr_fire      = enq_fire & !bypass_ok;

  assign mem_en    = rd_issue | wr_fire;
  assign mem_wmode = wr_fire;
  assign mem_wmask = wr_fire ? 2'b11 : 2'b00;

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (rd_issue) begin
      mem_addr = rd_ptr;
    end else if (wr_fire) begin
      mem_addr  = wr_ptr;
      mem_wdata = io_enq_bits;
    end
  end

  // Capture and bypass are mutually exclusive since bypass requires no read in flight.
  assign ob_push     = (!reset & inflight) | (enq_fire & bypass_ok);
  assign ob_push_dat = inflight ? mem_rdata : io_enq_bits;
  assign ob_tail     = ob_head ^ ob_cnt[0];

  assign io_count = r_cnt + {4'd0, inflight} + {3'd0, ob_cnt};

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      r_cnt    <= 5'd0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
      ob_head  <= 1'b0;
      addr_q   <= 4'd0;
      wdata_q  <= '0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + 4'd1;
      if (wr_fire)  wr_ptr <= wr_ptr + 4'd1;
      r_cnt    <= r_cnt + {4'd0, wr_fire} - {4'd0, rd_issue};
      inflight <= rd_issue;
      ob_cnt   <= ob_cnt + {1'b0, ob_push} - {1'b0, deq_fire};
      if (deq_fire) ob_head <= ~ob_head;
      if (mem_en) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ob_push) ob_dat[ob_tail] <= ob_push_dat;
  end

endmodule

// File: tb/tb_array_11_queue.sv
// Directed bench for array_11_queue with a behavioural 16x28 single-port SRAM attached to the RW0 port.
module tb_array_11_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_enq_valid;
  logic        io_enq_ready;
  logic [27:0] io_enq_bits;
  logic        io_deq_valid;
  logic        io_deq_ready;
  logic [27:0] io_deq_bits;
  logic [4:0]  io_count;
  logic [3:0]  mem_addr;
  logic        mem_en;
  logic        mem_wmode;
  logic [1:0]  mem_wmask;
  logic [27:0] mem_wdata;
  logic [27:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  array_11_queue dut (
    .clock(clock), .reset(reset),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready), .io_enq_bits(io_enq_bits),
    .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready), .io_deq_bits(io_deq_bits),
    .io_count(io_count),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // SRAM model: read data appears one cycle after the read, garbage otherwise.
  logic [27:0] ram [16];
  logic [31:0] rnd;
  always @(posedge clock) begin
    rnd = $urandom;
    if (mem_en && mem_wmode && mem_wmask == 2'b11) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_wmode) mem_rdata <= ram[mem_addr];
    else                      mem_rdata <= rnd[27:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_next;
    int next_in;
    int bound;

    reset = 1'b1; io_enq_valid = 1'b1; io_enq_bits = 28'h5A5; io_deq_ready = 1'b0;

    // Reset held two cycles with a pending enqueue
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_enq_ready", 32'(io_enq_ready), 0);
    end
    reset = 1'b0; io_enq_valid = 1'b0;
    #1;
    chk("post_rst_count", 32'(io_count), 0);
    chk("post_rst_deq_valid", 32'(io_deq_valid), 0);
    chk("post_rst_enq_ready", 32'(io_enq_ready), 1);

    // Bypass
    io_enq_valid = 1'b1; io_enq_bits = 28'h0000ABC; io_deq_ready = 1'b1;
    #1;
    chk("byp_mem_en", 32'(mem_en), 0);
    chk("byp_enq_ready", 32'(io_enq_ready), 1);
    tick();
    io_enq_valid = 1'b0;
    #1;
    chk("byp_deq_valid", 32'(io_deq_valid), 1);
    chk("byp_deq_bits", 32'(io_deq_bits), 32'h0000ABC);
    chk("byp_count1", 32'(io_count), 1);
    tick();
    chk("byp_count0", 32'(io_count), 0);
    chk("byp_deq_valid0", 32'(io_deq_valid), 0);

    // Fill: 0,1 bypass, 2..17 to RAM addr 0..15
    io_deq_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      io_enq_valid = 1'b1; io_enq_bits = 28'(i);
      #1;
      chk("fill_enq_ready", 32'(io_enq_ready), 1);
      if (i < 2) begin
        chk("fill_byp_mem_en", 32'(mem_en), 0);
      end else begin
        chk("fill_mem_en", 32'(mem_en), 1);
        chk("fill_wmode", 32'(mem_wmode), 1);
        chk("fill_wmask", 32'(mem_wmask), 3);
        chk("fill_addr", 32'(mem_addr), 32'(i - 2));
        chk("fill_wdata", 32'(mem_wdata), 32'(i));
      end
      tick();
    end
    io_enq_bits = 28'd18;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("full_count", 32'(io_count), 18);
      chk("full_enq_ready", 32'(io_enq_ready), 0);
      chk("full_mem_en", 32'(mem_en), 0);
      tick();
    end

    // Drain 0..17 without bubbles; reads cover addr 0..15
    io_enq_valid = 1'b0; io_deq_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk("drain_deq_valid", 32'(io_deq_valid), 1);
      chk("drain_deq_bits", 32'(io_deq_bits), 32'(k));
      if (k < 16) begin
        chk("drain_mem_en", 32'(mem_en), 1);
        chk("drain_wmode", 32'(mem_wmode), 0);
        chk("drain_wmask", 32'(mem_wmask), 0);
        chk("drain_addr", 32'(mem_addr), 32'(k));
      end
      tick();
    end
    chk("drain_empty_valid", 32'(io_deq_valid), 0);
    chk("drain_empty_count", 32'(io_count), 0);

    // Refill after wrap: 100,101 bypass, 102..106 to addr 0..4
    io_deq_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      io_enq_valid = 1'b1; io_enq_bits = 28'(100 + i);
      #1;
      chk("refill_enq_ready", 32'(io_enq_ready), 1);
      if (i >= 2) begin
        chk("refill_wmode", 32'(mem_wmode), 1);
        chk("refill_addr", 32'(mem_addr), 32'(i - 2));
      end
      tick();
    end
    io_enq_valid = 1'b0; io_deq_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("redrain_deq_valid", 32'(io_deq_valid), 1);
      chk("redrain_deq_bits", 32'(io_deq_bits), 32'(100 + k));
      if (k < 5) begin
        chk("redrain_rd", 32'({mem_en, mem_wmode}), 32'b10);
        chk("redrain_addr", 32'(mem_addr), 32'(k));
      end
      tick();
    end
    chk("redrain_empty", 32'(io_count), 0);

    // Contention: 200,201 in buffer, 202..205 in RAM, then enq and deq both held high
    io_deq_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      io_enq_valid = 1'b1; io_enq_bits = 28'(200 + i);
      #1;
      chk("cont_setup_ready", 32'(io_enq_ready), 1);
      tick();
    end
    chk("cont_setup_count", 32'(io_count), 6);
    exp_next = 200; next_in = 206;
    io_deq_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      io_enq_valid = 1'b1; io_enq_bits = 28'(next_in);
      #1;
      if (mem_en && !mem_wmode) chk("cont_rd_blocks_enq", 32'(io_enq_ready), 0);
      chk("cont_count_le18", 32'(io_count <= 5'd18), 1);
      if (io_deq_valid) begin
        chk("cont_order", 32'(io_deq_bits), 32'(exp_next));
        exp_next++;
      end
      if (io_enq_ready) next_in++;
      tick();
    end
    io_enq_valid = 1'b0;
    bound = 0;
    while (exp_next != next_in && bound < 100) begin
      #1;
      if (io_deq_valid) begin
        chk("cont_tail_order", 32'(io_deq_bits), 32'(exp_next));
        exp_next++;
      end
      bound++;
      tick();
    end
    chk("cont_all_out", 32'(exp_next), 32'(next_in));
    chk("cont_empty", 32'(io_count), 0);

    // Reset with 10 entries and a read in flight
    io_deq_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      io_enq_valid = 1'b1; io_enq_bits = 28'(300 + i);
      #1;
      chk("mid_setup_ready", 32'(io_enq_ready), 1);
      tick();
    end
    io_enq_valid = 1'b0; io_deq_ready = 1'b1;
    #1;
    chk("mid_head", 32'(io_deq_bits), 300);
    chk("mid_read_issue", 32'(mem_en), 1);
    tick();
    chk("mid_count10", 32'(io_count), 10);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_en", 32'(mem_en), 0);
    chk("mid_rst_enq_ready", 32'(io_enq_ready), 0);
    tick();
    reset = 1'b0; io_deq_ready = 1'b0;
    #1;
    chk("mid_post_count", 32'(io_count), 0);
    chk("mid_post_valid", 32'(io_deq_valid), 0);
    tick();
    chk("mid_no_stale", 32'(io_deq_valid), 0);
    io_enq_valid = 1'b1; io_enq_bits = 28'h1234567; io_deq_ready = 1'b1;
    #1;
    chk("mid_enq_ready", 32'(io_enq_ready), 1);
    chk("mid_byp_mem_en", 32'(mem_en), 0);
    tick();
    io_enq_valid = 1'b0;
    #1;
    chk("mid_first_valid", 32'(io_deq_valid), 1);
    chk("mid_first_bits", 32'(io_deq_bits), 32'h1234567);
    tick();
    chk("mid_final_count", 32'(io_count), 0);
    chk("mid_final_valid", 32'(io_deq_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/array_11_queue.md
# array_11_queue

Order-preserving 28-bit, 18-entry FIFO built around the 16x28 single-port masked SRAM macro (`array_11_ext`). It sits directly upstream of that macro and drives its RW0 port. It arbitrates the single port between enqueue writes and prefetch reads. A 2-entry registered output buffer plus an enqueue bypass path sustain one dequeue per cycle.

## Interface
Parameters:
- `DEPTH`, 16: RAM entries; fixed by the macro.
- `WIDTH`, 28: data width; fixed by the macro.
- `OB_DEPTH`, 2: output-buffer entries; fixed.

Ports:
- `clock`  in  1: single clock; also drives macro `RW0_clk`.
- `reset`  in  1: synchronous, active-high.
- `io_enq_valid`  in  1: enqueue request.
- `io_enq_ready`  out  1: enqueue accepted this cycle when high together with `io_enq_valid`.
- `io_enq_bits`  in  28: enqueue data.
- `io_deq_valid`  out  1: output-buffer head valid.
- `io_deq_ready`  in  1: consumer accepts the head.
- `io_deq_bits`  out  28: output-buffer head data.
- `io_count`  out  5: total occupancy = `r_cnt + inflight + ob_cnt`, range 0..18.
- `mem_addr`  out  4: to `RW0_addr`.
- `mem_en`  out  1: to `RW0_en`.
- `mem_wmode`  out  1: to `RW0_wmode`; 1 = write.
- `mem_wmask`  out  2: to `RW0_wmask`; always 2'b11 when writing, 2'b00 otherwise.
- `mem_wdata`  out  28: to `RW0_wdata`.
- `mem_rdata`  in  28: from `RW0_rdata`; valid one cycle after a read.

## Operation
State:
- `wr_ptr`, `rd_ptr`: 4-bit RAM pointers; wrap 15 -> 0 naturally.
- `r_cnt`: RAM entry count, 0..16.
- `inflight`: read issued last cycle.
- Output buffer: 2 entries with `ob_cnt` (0..2) and a head index.

Derived signals:
- `deq_fire = io_deq_valid & io_deq_ready`.
- `io_deq_valid = (ob_cnt != 0)`; `io_deq_bits` = head entry.
- `ob_credit = (ob_cnt + inflight - deq_fire) < 2`.
- `rd_issue = (r_cnt != 0) & ob_credit`.
  - Drives `mem_en=1`, `mem_wmode=0`, `mem_addr=rd_ptr`.
  - Next state: `rd_ptr++`, `r_cnt--`, `inflight<=1`.
- `bypass_ok = (r_cnt == 0) & !inflight & ob_credit`.
- `wr_ok = !rd_issue & !bypass_ok & (r_cnt < 16)`.
- `io_enq_ready = bypass_ok | wr_ok`.

Enqueue fire:
- If `bypass_ok`: data is pushed straight into the output buffer; no memory access.
- Else: `mem_en=1`, `mem_wmode=1`, `mem_wmask=2'b11`, `mem_addr=wr_ptr`, `mem_wdata=io_enq_bits`; then `wr_ptr++`, `r_cnt++`.

Port and buffer rules:
- Read has priority over write on the port; this drains the RAM toward the consumer.
- At most one memory operation per cycle. No write+read collision is possible.
- When `inflight` is set, `mem_rdata` is pushed into the output buffer; `inflight` clears unless a new read issues.
- `mem_rdata` is ignored when `inflight` is 0; it may be random garbage.
- Bypass and capture never coincide, because bypass requires `!inflight`.
- Output-buffer push and pop in the same cycle are both honoured.
- Ordering invariant: RAM data is always older than bypass data. Bypass is legal only when the RAM is empty and no read is in flight.
- With `mem_en=0`, `mem_addr`/`mem_wdata` hold their last values and are don't-care.

Reset (cycle where `reset` is high and the next state):
- Pointers, `r_cnt`, `inflight`, `ob_cnt` all go to 0.
- While `reset` is high: `io_enq_ready=0`, `mem_en=0`.
- After reset: `io_deq_valid=0`, `io_count=0`, `io_enq_ready=1`.
- Output-buffer data registers are not reset.
- Reset mid-operation discards all contents. A read issued in the reset cycle is suppressed; a capture pending from the prior cycle is dropped.

## Timing
- Bypass path: enqueue in cycle t -> `io_deq_valid` in t+1.
- RAM path: write in t; earliest read t+1; capture t+2; head visible t+3 (if the buffer is otherwise empty).
- Sustained throughput: 1 deq/cycle while `r_cnt>0` and `io_deq_ready=1`. Enqueue is then stalled because reads win the port.
- Combinational paths:
  - `io_deq_ready` -> `rd_issue` -> `mem_en` / `io_enq_ready`: permitted, documented.
  - No path from `io_enq_valid` to `io_enq_ready`.
- Full: `io_count==18` forces `io_enq_ready=0`.
- Empty: `io_count==0` forces `io_deq_valid=0`.

## Test plan
- **Reset:** hold `reset` 2 cycles with `io_enq_valid=1` -> `mem_en=0` and `io_enq_ready=0` during reset. Afterwards `io_count=0`, `io_deq_valid=0`, `io_enq_ready=1`.
- **Bypass:** empty queue, enq 28'h0000ABC at t with `io_deq_ready=1` -> `mem_en=0` at t; `io_deq_valid=1` and bits 28'h0000ABC at t+1; `io_count` returns to 0 at t+2.
- **Fill:** `io_deq_ready=0`, enq values 0..18 back-to-back -> values 0,1 bypass. Values 2..17 are written to addr 0..15 with `mem_wmask=2'b11`. `io_enq_ready=0` once `io_count=18`; value 18 is held, not lost.
- **Drain with wrap:** from the full state, hold `io_deq_ready=1` -> deq 0..17 in order, one per cycle with no bubble. Reads cover addr 0..15. Refill 5 more and drain -> addresses continue 0..4 after the pointer wrap.
- **Contention:** `r_cnt=4`, `io_enq_valid=1` and `io_deq_ready=1` continuously -> on every read cycle `io_enq_ready=0` and `mem_wmode=0`. All data emerges in enqueue order; `io_count` never exceeds 18.
- **Reset mid-flight:** `io_count=10` with a read in flight, pulse `reset` 1 cycle -> next cycle `io_count=0`, `io_deq_valid=0`. Then enqueue 28'h1234567 -> it is the first value dequeued; no stale data appears.
